// File: rtl/keccak_sponge_pkg.sv
// Shared types and widths for the Keccak sponge controller and its lane counter.
package keccak_sponge_pkg;

    localparam int LANE_W  = 5;
    localparam int BLOCK_W = 8;

    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        ABSORB  = 4'b0010,
        PERM    = 4'b0100,
        SQUEEZE = 4'b1000
    } sponge_state_t;

endpackage

// File: rtl/keccak_lane_counter.sv
// Lane index counter with synchronous clear, increment enable and runtime terminal count.
module keccak_lane_counter
    import keccak_sponge_pkg::*;
(
    input  logic              clk,
    input  logic              clear,
    input  logic              inc,
    input  logic [LANE_W-1:0] limit,
    output logic [LANE_W-1:0] idx,
    output logic              at_limit
);

    assign at_limit = (idx == limit);

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // always_ff reads the pre-edge values regardless of evaluation order.
    always_ff @(posedge clk) begin
        if (clear) begin
            idx <= '0;
        end else if (inc) begin
            idx <= at_limit ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/keccak_sponge_control.sv
// Sponge sequencing: absorb rate lanes, run the permutation, squeeze output lanes.
module keccak_sponge_control
    import keccak_sponge_pkg::*;
#(
    parameter int RATE_LANES = 17,
    parameter int OUT_LANES  = 4
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic               InValid,
    input  logic               InLast,
    output logic               InReady,
    output logic               AbsorbEn,
    output logic               StateClear,
    output logic [LANE_W-1:0]  LaneIdx,
    output logic               PermReset,
    input  logic               PermReady,
    output logic               OutValid,
    input  logic               OutReady,
    output logic               OutLast,
    output logic               Busy,
    output logic [BLOCK_W-1:0] BlockCount
);

    sponge_state_t     state;
    logic              last_flag;
    logic              perm_first;
    logic              lane_clear;
    logic              lane_inc;
    logic              lane_at_limit;
    logic [LANE_W-1:0] lane_limit;

    // Outputs are decoded from the one-hot state register; only StateClear and
    // AbsorbEn also follow same-cycle inputs, and both are suppressed under Reset.
    assign InReady    = (state == ABSORB);
    assign AbsorbEn   = (state == ABSORB) && InValid && !Reset;
    assign StateClear = (state == IDLE) && Start && !Reset;
    assign PermReset  = (state != PERM);
    assign OutValid   = (state == SQUEEZE);
    assign OutLast    = (state == SQUEEZE) && lane_at_limit;
    assign Busy       = (state != IDLE);

    assign lane_clear = Reset || StateClear;
    assign lane_inc   = ((state == ABSORB) && InValid) || ((state == SQUEEZE) && OutReady);
    assign lane_limit = (state == SQUEEZE) ? LANE_W'(OUT_LANES - 1) : LANE_W'(RATE_LANES - 1);

    keccak_lane_counter u_lane_counter (
        .clk      (Clock),
        .clear    (lane_clear),
        .inc      (lane_inc),
        .limit    (lane_limit),
        .idx      (LaneIdx),
        .at_limit (lane_at_limit)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= IDLE;
            last_flag  <= 1'b0;
            perm_first <= 1'b0;
            BlockCount <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        BlockCount <= '0;
                        last_flag  <= 1'b0;
                        state      <= ABSORB;
                    end
                end
                ABSORB: begin
                    if (InValid && lane_at_limit) begin
                        last_flag  <= InLast;
                        perm_first <= 1'b1;
                        if (BlockCount != '1) BlockCount <= BlockCount + 1'b1;
                        state      <= PERM;
                    end
                end
                PERM: begin
                    // The round controller's Ready may still be high from the previous run.
                    perm_first <= 1'b0;
                    if (!perm_first && PermReady) begin
                        state <= last_flag ? SQUEEZE : ABSORB;
                    end
                end
                SQUEEZE: begin
                    if (OutReady && lane_at_limit) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_sponge_control.sv
// Directed bench for keccak_sponge_control at RATE_LANES=17, OUT_LANES=4.
module tb_keccak_sponge_control;

    logic       Clock = 1'b0;
    logic       Reset, Start, InValid, InLast, PermReady, OutReady;
    logic       InReady, AbsorbEn, StateClear, PermReset, OutValid, OutLast, Busy;
    logic [4:0] LaneIdx;
    logic [7:0] BlockCount;

    int checks   = 0;
    int failures = 0;

    always #5 Clock = ~Clock;

    keccak_sponge_control #(.RATE_LANES(17), .OUT_LANES(4)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Start      (Start),
        .InValid    (InValid),
        .InLast     (InLast),
        .InReady    (InReady),
        .AbsorbEn   (AbsorbEn),
        .StateClear (StateClear),
        .LaneIdx    (LaneIdx),
        .PermReset  (PermReset),
        .PermReady  (PermReady),
        .OutValid   (OutValid),
        .OutReady   (OutReady),
        .OutLast    (OutLast),
        .Busy       (Busy),
        .BlockCount (BlockCount)
    );

    typedef struct {
        logic rst, start, iv, il, pr, ordy;
        logic in_ready, absorb_en, state_clear, perm_reset, out_valid, out_last, busy;
        logic [4:0] lane;
        logic [7:0] blocks;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [19:0] pack_exp(input vec_t v);
        return {v.in_ready, v.absorb_en, v.state_clear, v.perm_reset, v.out_valid,
                v.out_last, v.busy, v.lane, v.blocks};
    endfunction

    function automatic logic [19:0] pack_act();
        return {InReady, AbsorbEn, StateClear, PermReset, OutValid, OutLast, Busy,
                LaneIdx, BlockCount};
    endfunction

    task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change just after the falling edge; outputs are checked 1 time unit later.
    task automatic next_cycle();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic absorb_block(input logic last, input bit chk);
        for (int i = 0; i < 17; i++) begin
            InValid = 1'b1;
            InLast  = last && (i == 16);
            #1;
            if (chk) begin
                check("absorb_lane", 20'(LaneIdx), 20'(i));
                check("absorb_en", {19'd0, AbsorbEn}, 20'd1);
            end
            next_cycle();
        end
        InValid = 1'b0;
        InLast  = 1'b0;
    endtask

    // PermReady is given on PERM cycle n (n >= 2); earlier cycles must hold PermReset low.
    task automatic perm_wait(input int n, input bit chk);
        for (int c = 1; c <= n; c++) begin
            PermReady = (c == n);
            #1;
            if (chk) check("perm_reset_low", {19'd0, PermReset}, 20'd0);
            next_cycle();
        end
        PermReady = 1'b0;
    endtask

    task automatic squeeze(input int stall_at, input int stall_n);
        for (int i = 0; i < 4; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_n; s++) begin
                    OutReady = 1'b0;
                    #1;
                    check("stall_hold", {13'd0, OutValid, OutLast, LaneIdx}, {13'd0, 2'b10, 5'(i)});
                    next_cycle();
                end
            end
            OutReady = 1'b1;
            #1;
            check("squeeze_lane", {13'd0, OutValid, OutLast, LaneIdx},
                  {13'd0, 1'b1, (i == 3), 5'(i)});
            next_cycle();
        end
        OutReady = 1'b0;
    endtask

    task automatic start_msg();
        Start = 1'b1;
        #1;
        check("start_clear", {19'd0, StateClear}, 20'd1);
        next_cycle();
        Start = 1'b0;
    endtask

    initial begin
        //          rst st iv il pr or | ir ae sc pr ov ol bz lane blocks
        vecs[0] = '{0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0, 5'd0, 8'd0};
        vecs[1] = '{0, 1, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0, 0, 5'd0, 8'd0};
        vecs[2] = '{0, 0, 1, 0, 0, 0,   1, 1, 0, 1, 0, 0, 1, 5'd0, 8'd0};
        vecs[3] = '{0, 1, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0, 1, 5'd1, 8'd0};
        vecs[4] = '{0, 0, 1, 0, 0, 0,   1, 1, 0, 1, 0, 0, 1, 5'd1, 8'd0};
        vecs[5] = '{0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0, 1, 5'd2, 8'd0};
        vecs[6] = '{0, 0, 1, 0, 0, 0,   1, 1, 0, 1, 0, 0, 1, 5'd2, 8'd0};
        vecs[7] = '{1, 0, 1, 0, 1, 0,   1, 0, 0, 1, 0, 0, 1, 5'd3, 8'd0};
        vecs[8] = '{0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 0, 5'd0, 8'd0};
        vecs[9] = '{0, 1, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0, 0, 5'd0, 8'd0};

        Reset = 1'b1; Start = 1'b0; InValid = 1'b0; InLast = 1'b0;
        PermReady = 1'b0; OutReady = 1'b0;
        @(negedge Clock);
        next_cycle();
        next_cycle();

        // Reset state, alternating InValid, Start ignored in ABSORB, mid-ABSORB reset.
        for (int i = 0; i < 10; i++) begin
            Reset = vecs[i].rst; Start = vecs[i].start; InValid = vecs[i].iv;
            InLast = vecs[i].il; PermReady = vecs[i].pr; OutReady = vecs[i].ordy;
            #1;
            check($sformatf("vec%0d", i), pack_act(), pack_exp(vecs[i]));
            next_cycle();
        end
        Reset = 1'b0; Start = 1'b0; InValid = 1'b0; PermReady = 1'b0;

        // Single block (the table's last row started the message).
        absorb_block(1'b1, 1'b1);
        perm_wait(13, 1'b1);
        squeeze(4, 0);
        #1;
        check("single_idle", {12'd0, Busy, PermReset, 6'd0}, {12'd0, 1'b0, 1'b1, 6'd0});
        check("single_blocks", 20'(BlockCount), 20'd1);

        // Two blocks: after the first permutation the controller asks for more input.
        start_msg();
        absorb_block(1'b0, 1'b0);
        perm_wait(5, 1'b0);
        #1;
        check("more_blocks", {14'd0, InReady, LaneIdx}, {14'd0, 1'b1, 5'd0});
        check("more_blocks_cnt", 20'(BlockCount), 20'd1);
        absorb_block(1'b1, 1'b0);
        perm_wait(3, 1'b0);
        squeeze(4, 0);
        #1;
        check("two_blocks", 20'(BlockCount), 20'd2);

        // Output backpressure held at lane 2.
        start_msg();
        absorb_block(1'b1, 1'b0);
        perm_wait(2, 1'b0);
        squeeze(2, 5);
        #1;
        check("bp_idle", {19'd0, Busy}, 20'd0);

        // Stale PermReady in PERM cycle 1 is ignored, then Reset in PERM cycle 6.
        start_msg();
        absorb_block(1'b1, 1'b0);
        PermReady = 1'b1;
        next_cycle();
        PermReady = 1'b0;
        #1;
        check("stale_ready", {17'd0, PermReset, OutValid, InReady}, 20'd0);
        for (int c = 2; c < 6; c++) next_cycle();
        Reset = 1'b1;
        PermReady = 1'b1;
        next_cycle();
        Reset = 1'b0;
        PermReady = 1'b0;
        #1;
        check("perm_reset_vals", pack_act(), {7'b0001000, 5'd0, 8'd0});
        start_msg();
        #1;
        check("restart", {14'd0, InReady, LaneIdx}, {14'd0, 1'b1, 5'd0});

        // BlockCount saturation over 300 non-final blocks.
        for (int b = 0; b < 300; b++) begin
            absorb_block(1'b0, 1'b0);
            perm_wait(2, 1'b0);
        end
        #1;
        check("saturate", 20'(BlockCount), 20'd255);
        absorb_block(1'b0, 1'b0);
        perm_wait(2, 1'b0);
        #1;
        check("saturate_hold", 20'(BlockCount), 20'd255);

        Reset = 1'b1;
        next_cycle();
        Reset = 1'b0;
        #1;
        check("final_reset", pack_act(), {7'b0001000, 5'd0, 8'd0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keccak_sponge_control.md
KECCAK_SPONGE_CONTROL -- requirements
Module: keccak_sponge_control

Interface
REQ-001 SHALL have parameter RATE_LANES, default 17, meaning lanes per absorbed block; legal range 2..25.
REQ-002 SHALL have parameter OUT_LANES, default 4, meaning lanes squeezed per message; legal range 1..RATE_LANES.
REQ-003 SHALL have port Clock  input  1  sole clock, rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port Start  input  1  one-cycle request to begin a new message.
REQ-006 SHALL have ports InValid/InLast  input  1/1  lane valid; last-block flag, sampled on the final lane of a block only.
REQ-007 SHALL have port InReady  output  1  controller accepts a lane this cycle.
REQ-008 SHALL have ports AbsorbEn/StateClear  output  1/1  XOR lane into the state at LaneIdx; zero the state.
REQ-009 SHALL have port LaneIdx  output  5  current absorb or squeeze lane index.
REQ-010 SHALL have ports PermReset/PermReady  output/input  1/1  hold/release the permutation round controller; its completion flag.
REQ-011 SHALL have ports OutValid/OutReady/OutLast  output/input/output  1/1/1  squeeze handshake; final output lane.
REQ-012 SHALL have ports Busy/BlockCount  output  1/8  not idle; blocks absorbed in the current message.

Function
REQ-013 SHALL implement FSM states IDLE, ABSORB, PERM, SQUEEZE.
REQ-014 IDLE: PermReset=1, InReady=0, OutValid=0. Start=1 -> StateClear=1 combinationally that cycle, BlockCount<=0, LaneIdx<=0, next ABSORB.
REQ-015 Start SHALL be ignored in every state except IDLE.
REQ-016 ABSORB: InReady=1, PermReset=1. AbsorbEn=InValid. A transfer (InValid&InReady) SHALL increment LaneIdx.
REQ-017 Transfer at LaneIdx=RATE_LANES-1 -> LaneIdx<=0, last flag<=InLast, BlockCount<=BlockCount+1 saturating at 255, next PERM.
REQ-018 PERM: PermReset=0, InReady=0, AbsorbEn=0. PermReady SHALL be ignored in the first PERM cycle, because of a stale Ready from the previous run.
REQ-019 PERM, PermReady=1 from the second cycle on -> next SQUEEZE if the last flag is set, else ABSORB; PermReset SHALL be 1 again from the next cycle.
REQ-020 SQUEEZE: OutValid=1, PermReset=1, LaneIdx is the output lane. A transfer (OutValid&OutReady) SHALL increment LaneIdx.
REQ-021 OutLast SHALL be asserted only when OutValid=1 and LaneIdx=OUT_LANES-1. A transfer at that index -> LaneIdx<=0, next IDLE.
REQ-022 OutValid and LaneIdx SHALL remain stable while OutReady=0.
REQ-023 Busy SHALL be 1 in every state except IDLE.
REQ-024 The latency from the final-lane transfer to PermReset=0 SHALL be 1 cycle. The latency from accepted PermReady to OutValid=1 (last block) or InReady=1 (more blocks) SHALL be 1 cycle.

Reset
REQ-025 Reset=1 at any clock edge, including mid-ABSORB, mid-PERM or mid-SQUEEZE, SHALL force IDLE at the next cycle.
REQ-026 Reset values: LaneIdx=0, BlockCount=0, last flag=0, InReady=0, AbsorbEn=0, StateClear=0, OutValid=0, OutLast=0, Busy=0, PermReset=1.
REQ-027 Reset SHALL take priority over Start, InValid and PermReady in the same cycle.

Structure
REQ-028 Package keccak_sponge_pkg SHALL hold the FSM state encoding (one-hot, 4 bits), the LaneIdx width constant (5) and the BlockCount width constant (8).
REQ-029 Sub-module keccak_lane_counter SHALL implement LaneIdx, with synchronous clear, increment enable and terminal-count compare against a runtime limit (RATE_LANES-1 or OUT_LANES-1).
REQ-030 The block SHALL contain no datapath; lane data is routed outside it.

Verification (RATE_LANES=17, OUT_LANES=4)
REQ-031 Single block: Start, 17 back-to-back lanes, InLast=1 on lane 16 -> AbsorbEn 17 cycles with LaneIdx 0..16; PermReset=0 next cycle; PermReady after 13 cycles -> OutValid with LaneIdx 0..3, OutLast on 3; back to IDLE; BlockCount=1.
REQ-032 Two blocks: InLast=0 on first block -> after PermReady, InReady=1 with LaneIdx=0; second block with InLast=1 -> squeeze; BlockCount=2.
REQ-033 Backpressure: InValid alternating 1/0 -> LaneIdx advances only on transfers; OutReady=0 for 5 cycles at LaneIdx=2 -> OutValid=1 and LaneIdx=2 held.
REQ-034 Reset asserted in PERM cycle 6 -> next cycle IDLE, PermReset=1, all other outputs at reset values; Start then begins cleanly.
REQ-035 Ignored events: Start during ABSORB -> no StateClear; PermReady=1 in the first PERM cycle -> remain in PERM.
REQ-036 Saturation: 300 blocks with InLast=0 -> BlockCount=255 and holds.
